// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also provides a pow10 helper that is used to size the overflow threshold.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int DEF_DIGITS  = 4;
  localparam int DEF_BIN_W   = 14;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAX_DEC = pow10(DEF_DIGITS) - 1;
  localparam logic [BCD_DIGIT_W*DEF_DIGITS-1:0] BCD_NINES = {DEF_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more.
// The sum stays 4 bits wide, so nothing carries into the next digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock; result held until next done.
// Optional macro BCD_SATURATE_EN: out-of-range inputs show all nines instead of the low digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [BIN_W-1:0]             bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                         ovf
);
  localparam int          SW    = BCD_DIGIT_W * DIGITS;
  localparam int          CW    = $clog2(BIN_W + 1);
  localparam int unsigned MAX_V = pow10(DIGITS) - 1;

  state_t          state_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [SW-1:0]   scratch_reg;
  logic [CW-1:0]   cnt_reg;
  logic            ovf_next_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [SW-1:0]   bcd_reg;
  logic            ovf_reg;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   result_next;
  logic            in_ovf;
  logic            unused_msb;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (scratch_reg[BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
        .dout (adj[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Top scratch bit is shifted out: this is what yields the value modulo 10^DIGITS.
  assign unused_msb = adj[SW-1];
  assign in_ovf     = (32'(bin_in) > MAX_V);

`ifdef BCD_SATURATE_EN
  assign result_next = ovf_next_reg ? {DIGITS{4'h9}} : scratch_reg;
`else
  assign result_next = scratch_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      ovf_next_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg      <= bin_in;
            scratch_reg  <= '0;
            cnt_reg      <= CW'(BIN_W);
            ovf_next_reg <= in_ovf;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_reg, bin_reg} <= {adj[SW-2:0], bin_reg, 1'b0};
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) state_reg <= DONE;
        end
        DONE: begin
          bcd_reg   <= result_next;
          ovf_reg   <= ovf_next_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign ovf  = ovf_reg;
endmodule
